// File: rtl/cla_pkg.sv
// Shared widths and types for the 28-bit carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_DATA_W  = 28;
    localparam int unsigned CLA_GRP_W   = 4;
    localparam int unsigned CLA_NUM_GRP = CLA_DATA_W / CLA_GRP_W;

    typedef logic [CLA_DATA_W-1:0] cla_data_t;

endpackage

// File: rtl/cla_4bit_block.sv
// First-level 4-bit lookahead group: sum bits plus group generate/propagate.
module cla_4bit_block (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_gg,
    output logic       o_gp
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = i_a & i_b;
        p = i_a ^ i_b;

        // Every internal carry is a flat sum of products of g, p and i_cin.
        c[0] = i_cin;
        c[1] = g[0] | (p[0] & i_cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & i_cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & i_cin);

        o_gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        o_gp = &p;

        o_sum = p ^ c;
    end

endmodule

// File: rtl/cla_28bit.sv
// 28-bit two-level carry-lookahead adder: {o_carry,o_sum} = a + b + cin.
// Defining CLA_28BIT_REG_OUT_EN adds a one-cycle output register with sync reset.
module cla_28bit
    import cla_pkg::*;
#(
    parameter int unsigned DATA_W = CLA_DATA_W,
    parameter int unsigned GRP_W  = CLA_GRP_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic              i_carry,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_carry
);

    localparam int unsigned NUM_GRP = DATA_W / GRP_W;

    logic [NUM_GRP-1:0] grp_gg;
    logic [NUM_GRP-1:0] grp_gp;
    logic [NUM_GRP:0]   grp_c;
    cla_data_t          sum_comb;

    for (genvar k = 0; k < NUM_GRP; k++) begin : g_grp
        cla_4bit_block u_grp (
            .i_a   (i_data_a[k*GRP_W +: GRP_W]),
            .i_b   (i_data_b[k*GRP_W +: GRP_W]),
            .i_cin (grp_c[k]),
            .o_sum (sum_comb[k*GRP_W +: GRP_W]),
            .o_gg  (grp_gg[k]),
            .o_gp  (grp_gp[k])
        );
    end

    // Second level: each group carry is the OR of GG[j] & GP[k:j+1] terms plus
    // the GP[k:0] & cin term, so no carry waits on a lower group carry.
    always_comb begin
        logic c_next;
        logic term;
        grp_c    = '0;
        grp_c[0] = i_carry;
        for (int unsigned k = 0; k < NUM_GRP; k++) begin
            c_next = 1'b0;
            for (int unsigned j = 0; j <= k; j++) begin
                term = grp_gg[j];
                for (int unsigned m = j + 1; m <= k; m++) begin
                    term = term & grp_gp[m];
                end
                c_next = c_next | term;
            end
            term = i_carry;
            for (int unsigned m = 0; m <= k; m++) begin
                term = term & grp_gp[m];
            end
            grp_c[k+1] = c_next | term;
        end
    end

`ifdef CLA_28BIT_REG_OUT_EN
    cla_data_t sum_d;
    cla_data_t sum_q;
    logic      carry_d;
    logic      carry_q;

    always_comb begin
        sum_d   = sum_comb;
        carry_d = grp_c[NUM_GRP];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign o_sum   = sum_q;
    assign o_carry = carry_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = i_clk ^ i_rst;
    assign o_sum          = sum_comb;
    assign o_carry        = grp_c[NUM_GRP];
`endif

endmodule

// File: tb/tb_cla_28bit.sv
// Directed-vector and random self-check for cla_28bit, combinational or registered build.
module tb_cla_28bit;

    logic        clk;
    logic        rst;
    logic [27:0] a;
    logic [27:0] b;
    logic        cin;
    logic [27:0] sum;
    logic        cout;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [27:0] a;
        logic [27:0] b;
        logic        cin;
        logic [27:0] exp_sum;
        logic        exp_carry;
    } vec_t;

    vec_t vecs [12];

    cla_28bit #(.DATA_W(28), .GRP_W(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_data_a (a),
        .i_data_b (b),
        .i_carry  (cin),
        .o_sum    (sum),
        .o_carry  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [28:0] exp);
        checks++;
        if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL %s: got carry=%0b sum=%07h, want carry=%0b sum=%07h",
                     tag, cout, sum, exp[28], exp[27:0]);
        end
    endtask

    task automatic apply(input logic [27:0] va, input logic [27:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
`ifdef CLA_28BIT_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        logic [27:0] ra;
        logic [27:0] rb;
        logic        rc;
        logic [28:0] gold;

        checks = 0;
        errors = 0;

        vecs[0]  = '{28'h0000000, 28'h0000000, 1'b1, 28'h0000001, 1'b0};
        vecs[1]  = '{28'h00000FF, 28'h0000000, 1'b1, 28'h0000100, 1'b0};
        vecs[2]  = '{28'h00000FF, 28'h00000FF, 1'b1, 28'h00001FF, 1'b0};
        vecs[3]  = '{28'hFFFFFFF, 28'h0000000, 1'b1, 28'h0000000, 1'b1};
        vecs[4]  = '{28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 28'hFFFFFFF, 1'b1};
        vecs[5]  = '{28'h0000000, 28'h0000000, 1'b0, 28'h0000000, 1'b0};
        vecs[6]  = '{28'hFFFFFFF, 28'h0000001, 1'b0, 28'h0000000, 1'b1};
        vecs[7]  = '{28'h1234567, 28'h89ABCDE, 1'b0, 28'h9BE0245, 1'b0};
        vecs[8]  = '{28'h8000000, 28'h8000000, 1'b0, 28'h0000000, 1'b1};
        vecs[9]  = '{28'hAAAAAAA, 28'h5555555, 1'b1, 28'h0000000, 1'b1};
        vecs[10] = '{28'h000000F, 28'h0000001, 1'b0, 28'h0000010, 1'b0};
        vecs[11] = '{28'h7FFFFFF, 28'h0000000, 1'b1, 28'h8000000, 1'b0};

        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;

`ifdef CLA_28BIT_REG_OUT_EN
        a   = 28'hFFFFFFF;
        cin = 1'b1;
        @(posedge clk);
        #1;
        compare("reset_state", 29'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].cin);
            compare($sformatf("vec%0d", i), {vecs[i].exp_carry, vecs[i].exp_sum});
        end

        for (int i = 0; i < 120; i++) begin
            ra   = 28'($urandom);
            rb   = 28'($urandom);
            rc   = 1'($urandom_range(1, 0));
            gold = {1'b0, ra} + {1'b0, rb} + {28'b0, rc};
            apply(ra, rb, rc);
            compare($sformatf("rand%0d", i), gold);
        end

`ifdef CLA_28BIT_REG_OUT_EN
        // Reset in the middle of a stream: the in-flight sum is dropped, then data resumes.
        apply(28'h1234567, 28'h89ABCDE, 1'b0);
        compare("pre_reset", 29'h09BE0245);
        a   = 28'hFFFFFFF;
        b   = 28'hFFFFFFF;
        cin = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        compare("mid_reset", 29'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare("post_reset", 29'h1FFFFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
